// File: rtl/ula_32_bits_if.sv
// ula_32_bits_if
// Operand/result bus of the 32-bit ALU.
//   A, B      : operands, unsigned (B[4:0] is also the shift amount)
//   Cin, Bin  : carry-in for ADD, borrow-in for SUB
//   op_sel    : operation select
//   resultado : registered result
//   Cout, Bout: registered carry-out / borrow-out
// master drives operands and reads results; slave is the ALU itself.
interface ula_32_bits_if;
  logic [31:0] A;
  logic [31:0] B;
  logic        Cin;
  logic        Bin;
  logic [2:0]  op_sel;
  logic [31:0] resultado;
  logic        Cout;
  logic        Bout;

  modport master (
    output A, B, Cin, Bin, op_sel,
    input  resultado, Cout, Bout
  );

  modport slave (
    input  A, B, Cin, Bin, op_sel,
    output resultado, Cout, Bout
  );
endinterface

// File: rtl/ula_32_bits.sv
// ula_32_bits
// 32-bit registered ALU: eight operations selected by op_sel, one result
// per clock, one cycle of latency.
//   clk : system clock, rising edge
//   rst : synchronous active-high reset, clears result and flags
//   bus : ula_32_bits_if.slave (operands in, registered result/flags out)
module ula_32_bits (
  input  logic          clk,
  input  logic          rst,
  ula_32_bits_if.slave  bus
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOR = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_SRL = 3'b111;

  logic [32:0] sum_ext;
  logic [32:0] diff_ext;
  logic [4:0]  shamt;
  logic [31:0] res_nxt;
  logic        cout_nxt;
  logic        bout_nxt;

  // 33-bit arithmetic: bit 32 of the sum is the carry; bit 32 of the
  // difference is set exactly when A < B + Bin (the true result is negative,
  // including the B = FFFFFFFF, Bin = 1 corner).
  assign sum_ext  = {1'b0, bus.A} + {1'b0, bus.B} + {32'b0, bus.Cin};
  assign diff_ext = {1'b0, bus.A} - {1'b0, bus.B} - {32'b0, bus.Bin};
  assign shamt    = bus.B[4:0];

  always_comb begin
    res_nxt  = 32'h0;
    cout_nxt = 1'b0;
    bout_nxt = 1'b0;
    case (bus.op_sel)
      OP_ADD: begin
        res_nxt  = sum_ext[31:0];
        cout_nxt = sum_ext[32];
      end
      OP_SUB: begin
        res_nxt  = diff_ext[31:0];
        bout_nxt = diff_ext[32];
      end
      OP_AND:  res_nxt = bus.A & bus.B;
      OP_OR:   res_nxt = bus.A | bus.B;
      OP_XOR:  res_nxt = bus.A ^ bus.B;
      OP_NOR:  res_nxt = ~(bus.A | bus.B);
      OP_SLL:  res_nxt = bus.A << shamt;
      OP_SRL:  res_nxt = bus.A >> shamt;
      default: res_nxt = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.resultado <= 32'h0;
      bus.Cout      <= 1'b0;
      bus.Bout      <= 1'b0;
    end else begin
      bus.resultado <= res_nxt;
      bus.Cout      <= cout_nxt;
      bus.Bout      <= bout_nxt;
    end
  end

endmodule

// File: tb/tb_ula_32_bits.sv
module tb_ula_32_bits;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  ula_32_bits_if bus ();

  ula_32_bits dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Reference model: plain wide integer arithmetic, returns {Cout, Bout, result}.
  function automatic logic [33:0] ref_op(input logic [31:0] a, input logic [31:0] b,
                                         input logic cin, input logic bin,
                                         input logic [2:0] op);
    longint unsigned la, lb, s;
    logic [31:0] r;
    logic [4:0]  sh;
    logic        co, bo;
    la = a;
    lb = b;
    sh = b[4:0];
    co = 1'b0;
    bo = 1'b0;
    r  = 32'h0;
    case (op)
      3'd0: begin
        s  = la + lb + cin;
        r  = s[31:0];
        co = (s > 64'hFFFF_FFFF);
      end
      3'd1: begin
        s  = la - lb - bin;
        r  = s[31:0];
        bo = (la < lb + bin);
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = ~(a | b);
      3'd6: r = a << sh;
      default: r = a >> sh;
    endcase
    return {co, bo, r};
  endfunction

  logic [33:0] last_exp;

  task automatic check_out(input string tag, input logic [33:0] exp);
    check({tag, "_res"},  bus.resultado, exp[31:0]);
    check({tag, "_cout"}, {31'b0, bus.Cout}, {31'b0, exp[33]});
    check({tag, "_bout"}, {31'b0, bus.Bout}, {31'b0, exp[32]});
  endtask

  // Drive one operation at the falling edge, check it just after the next rising edge.
  task automatic step(input logic [31:0] a, input logic [31:0] b, input logic cin,
                      input logic bin, input logic [2:0] op, input logic r,
                      input string tag);
    logic [33:0] exp;
    @(negedge clk);
    bus.A      = a;
    bus.B      = b;
    bus.Cin    = cin;
    bus.Bin    = bin;
    bus.op_sel = op;
    rst        = r;
    @(posedge clk);
    #1;
    exp = r ? 34'h0 : ref_op(a, b, cin, bin, op);
    check_out(tag, exp);
    last_exp = exp;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus.A = '0; bus.B = '0; bus.Cin = 1'b0; bus.Bin = 1'b0; bus.op_sel = 3'd0;

    step(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 3'b000, 1'b1, "reset");
    check("reset_const", bus.resultado, 32'h0);

    step(32'h1234_5678, 32'h8765_4321, 1'b0, 1'b0, 3'b000, 1'b0, "add1");
    check("add1_const", bus.resultado, 32'h9999_9999);
    step(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 3'b000, 1'b0, "add_wrap");
    check("add_wrap_cout", {31'b0, bus.Cout}, 32'h1);
    step(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1, 3'b000, 1'b0, "add_cin");
    step(32'h8765_4321, 32'h1234_5678, 1'b1, 1'b0, 3'b001, 1'b0, "sub1");
    check("sub1_const", bus.resultado, 32'h7530_ECA9);
    step(32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0, 3'b001, 1'b0, "sub_neg");
    step(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 3'b001, 1'b0, "sub_bin");
    check("sub_bin_const", bus.resultado, 32'hFFFF_FFFF);
    step(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 3'b001, 1'b0, "sub_b33");
    check("sub_b33_bout", {31'b0, bus.Bout}, 32'h1);
    step(32'h0000_0005, 32'h0000_0005, 1'b0, 1'b0, 3'b001, 1'b0, "sub_eq");

    for (int op = 2; op <= 5; op++)
      step(32'hF0F0_F0F0, 32'h0F0F_0F0F, 1'b1, 1'b1, 3'(op), 1'b0, $sformatf("logic%0d", op));

    step(32'h8000_0001, 32'h0000_0004, 1'b1, 1'b1, 3'b110, 1'b0, "sll4");
    check("sll4_const", bus.resultado, 32'h0000_0010);
    step(32'h8000_0001, 32'h0000_0004, 1'b0, 1'b0, 3'b111, 1'b0, "srl4");
    check("srl4_const", bus.resultado, 32'h0800_0000);
    step(32'h8000_0001, 32'h0000_0020, 1'b0, 1'b0, 3'b110, 1'b0, "sll0");
    check("sll0_const", bus.resultado, 32'h8000_0001);
    step(32'hDEAD_BEEF, 32'hFFFF_FFE1, 1'b0, 1'b0, 3'b111, 1'b0, "srl_hi");

    // Outputs must not follow the inputs or an asynchronous rst between edges.
    step(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, 3'b000, 1'b0, "pre_hold");
    @(negedge clk);
    rst = 1'b1;
    bus.A = 32'hAAAA_AAAA;
    bus.op_sel = 3'b011;
    #2;
    check_out("hold", last_exp);
    @(posedge clk);
    #1;
    check_out("sync_rst", 34'h0);

    // Random pipelined stream with occasional one-cycle resets.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a, b;
      logic [2:0]  op;
      a  = $urandom;
      b  = $urandom;
      op = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) b = {27'($urandom), 5'($urandom_range(0, 31))};
      if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFFF;
      step(a, b, 1'($urandom), 1'($urandom), op, ($urandom_range(0, 19) == 0),
           $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
